// File: rtl/gemm_tile_scheduler.sv
// Output-stationary GeMM tile walker: m/n/k loop nest, A/B read addresses, PE strobes, C writes.
// Latency: read addresses same cycle as issue, data_valid/acc_clr +1, C write +2.
// Backpressure: in_ready_i low stalls the loop counters; in-flight pipeline stages keep moving.
module gemm_tile_scheduler #(
    parameter int unsigned AddrWidth     = 16,
    parameter int unsigned SizeAddrWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_tiles_i,
    input  logic [SizeAddrWidth-1:0] K_tiles_i,
    input  logic [SizeAddrWidth-1:0] N_tiles_i,
    input  logic                     in_ready_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic                     issue_o,
    output logic                     data_valid_o,
    output logic                     acc_clr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned PW = 2 * SizeAddrWidth + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e state_q, state_d;

    logic [SizeAddrWidth-1:0] mt_q, kt_q, nt_q;
    logic [SizeAddrWidth-1:0] m_q, n_q, k_q;
    logic                     drain_q;

    logic dv_q, clr_q, wlast_q, we_q;
    logic [AddrWidth-1:0] cpend_q, c_addr_q;

    logic in_run, issue, k_last, n_last, m_last, start_ok;
    logic [PW-1:0] a_full, b_full, c_full;

    assign in_run   = (state_q == RUN);
    assign issue    = in_run && in_ready_i;
    assign k_last   = (k_q == kt_q - SizeAddrWidth'(1));
    assign n_last   = (n_q == nt_q - SizeAddrWidth'(1));
    assign m_last   = (m_q == mt_q - SizeAddrWidth'(1));
    assign start_ok = (state_q == IDLE) && start_i;

    // Full-width products; truncation to AddrWidth gives the modulo wrap.
    assign a_full = PW'(m_q) * PW'(kt_q) + PW'(k_q);
    assign b_full = PW'(k_q) * PW'(nt_q) + PW'(n_q);
    assign c_full = PW'(m_q) * PW'(nt_q) + PW'(n_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if ((|M_tiles_i) && (|K_tiles_i) && (|N_tiles_i)) state_d = RUN;
                    else                                              state_d = DONE;
                end
            end
            RUN: begin
                if (issue && k_last && n_last && m_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mt_q <= '0;
            kt_q <= '0;
            nt_q <= '0;
            m_q  <= '0;
            n_q  <= '0;
            k_q  <= '0;
        end else if (start_ok) begin
            mt_q <= M_tiles_i;
            kt_q <= K_tiles_i;
            nt_q <= N_tiles_i;
            m_q  <= '0;
            n_q  <= '0;
            k_q  <= '0;
        end else if (issue) begin
            if (k_last) begin
                k_q <= '0;
                if (n_last) begin
                    n_q <= '0;
                    m_q <= m_q + SizeAddrWidth'(1);
                end else begin
                    n_q <= n_q + SizeAddrWidth'(1);
                end
            end else begin
                k_q <= k_q + SizeAddrWidth'(1);
            end
        end
    end

    // Stage 1 mirrors the 1-cycle SRAM read; stage 2 is the PE result write-back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dv_q     <= 1'b0;
            clr_q    <= 1'b0;
            wlast_q  <= 1'b0;
            cpend_q  <= '0;
            we_q     <= 1'b0;
            c_addr_q <= '0;
        end else begin
            dv_q    <= issue;
            clr_q   <= issue && (k_q == '0);
            wlast_q <= issue && k_last;
            cpend_q <= AddrWidth'(c_full);
            we_q    <= wlast_q;
            if (wlast_q) c_addr_q <= cpend_q;
        end
    end

    assign sram_a_addr_o = in_run ? AddrWidth'(a_full) : '0;
    assign sram_b_addr_o = in_run ? AddrWidth'(b_full) : '0;
    assign issue_o       = issue;
    assign data_valid_o  = dv_q;
    assign acc_clr_o     = clr_q;
    assign sram_c_we_o   = we_q;
    assign sram_c_addr_o = c_addr_q;
    assign busy_o        = in_run || (state_q == DRAIN);
    assign done_o        = (state_q == DONE);

endmodule

// File: doc/gemm_tile_scheduler.md
Name: gemm_tile_scheduler

Overview:
Sequences a tiled GeMM over an M x N x K output-stationary PE grid. Each tile is one SRAM word holding an MxK block of A, a KxN block of B, or an MxN block of C. The block walks the tile loop nest (m, then n, then k innermost), generates SRAM A/B read addresses, PE valid and accumulator-clear strobes, and SRAM C write address and write-enable. It tolerates input-SRAM stalls through an issue handshake and reports busy and done to the host.

Parameters:
AddrWidth, 16, width of SRAM A/B/C tile addresses
SizeAddrWidth, 8, width of tile-count inputs and internal loop counters

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  start pulse; sampled only in IDLE
M_tiles_i  input  SizeAddrWidth  number of tile rows of A/C
K_tiles_i  input  SizeAddrWidth  number of tiles along reduction dimension
N_tiles_i  input  SizeAddrWidth  number of tile columns of B/C
in_ready_i  input  1  input SRAMs accept a read this cycle
sram_a_addr_o  output  AddrWidth  A tile read address
sram_b_addr_o  output  AddrWidth  B tile read address
issue_o  output  1  read issued this cycle (RUN and in_ready_i)
data_valid_o  output  1  A/B read data valid at PE inputs this cycle
acc_clr_o  output  1  PE accumulator loads rather than adds this cycle
sram_c_addr_o  output  AddrWidth  C tile write address
sram_c_we_o  output  1  C write enable, PE results valid
busy_o  output  1  high in RUN and DRAIN
done_o  output  1  single-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0. FSM in IDLE. Counters and latched sizes 0. Applies mid-operation too: the job is abandoned and no further C write occurs.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE with start_i=1:
  - Latch M_tiles_i, K_tiles_i and N_tiles_i. Clear counters m, n, k.
  - If all three sizes are nonzero, go to RUN. Otherwise go to DONE with no issue and no write.
- IDLE with start_i=0: stay in IDLE.
- start_i in any state other than IDLE is ignored. Size inputs are don't-care after latching.
- RUN address generation:
  - sram_a_addr_o = m*Kt + k.
  - sram_b_addr_o = k*Nt + n.
  - Both are combinational from the counters, computed at full product width and truncated to AddrWidth (modulo 2^AddrWidth).
  - Address outputs are 0 outside RUN.
- RUN issue and counter advance:
  - issue_o = in_ready_i.
  - On issue, k increments. At k=Kt-1, k wraps to 0 and n increments. At n=Nt-1, n wraps to 0 and m increments.
  - On the issue with m=Mt-1, n=Nt-1, k=Kt-1, go to DRAIN.
- Stall: in_ready_i=0 in RUN holds the counters and inserts a bubble. Stages already in flight still advance.
- Pipeline, for an issue in cycle t:
  - Cycle t+1: data_valid_o=1 (SRAM read latency is 1 cycle). acc_clr_o=1 in the same cycle iff the issued k was 0.
  - Cycle t+2: if the issued k was Kt-1, sram_c_we_o=1 and sram_c_addr_o=m*Nt+n of that issue (registered, truncated to AddrWidth). Outside a write, sram_c_addr_o holds its last value.
- DRAIN: stays exactly 2 cycles after the final issue, covering the final data_valid_o and the final sram_c_we_o, then goes to DONE.
- DONE: done_o=1 for one cycle, then IDLE. A new start_i is accepted in the cycle after DONE.
- Counts: one write per (m,n) pair, Mt*Nt writes per job, in m-major, n-minor order. Exactly Mt*Nt*Kt issues per job.
- Kt=1: every data_valid_o carries acc_clr_o=1 and is followed by a write.
- Back-to-back: consecutive C writes are possible every cycle when Kt=1 and in_ready_i is held high.

Test Plan:
1. Mt=Kt=Nt=1, in_ready_i=1, start at cycle 0:
   - A and B addresses 0 at cycle 1.
   - data_valid_o and acc_clr_o at cycle 2.
   - sram_c_we_o at cycle 3 with addr 0.
   - done_o at cycle 4.
2. Mt=2, Kt=3, Nt=2, in_ready_i=1:
   - 12 issues.
   - A address sequence 0,1,2,0,1,2,3,4,5,3,4,5.
   - B address sequence 0,2,4,1,3,5,0,2,4,1,3,5.
   - C writes to addresses 0,1,2,3, each 2 cycles after k=2.
   - acc_clr_o exactly 4 times.
3. Case 2 with in_ready_i toggled 1,0,1,0…:
   - Identical address, C-address and acc_clr_o sequences.
   - Bubbles inserted.
   - done_o only after the 4th write.
4. K_tiles_i=0 with start_i=1:
   - No issue, no sram_c_we_o.
   - done_o one cycle after start.
   - busy_o stays 0.
5. rst_ni asserted mid-RUN in case 2:
   - All outputs 0 immediately.
   - No further writes.
   - A subsequent start_i with Mt=Kt=Nt=1 completes as in scenario 1.
6. start_i pulsed during RUN:
   - Ignored; sequence unchanged.
   - start_i asserted in the cycle after done_o begins a new job.
